// File: rtl/nibble_splitter.sv
`default_nettype none
// ============================================================================
// Module   : nibble_splitter
// Brief    : Splits each accepted byte into two 4-bit nibbles over a
//            valid/ready interface; the nibble order is set by HIGH_FIRST.
// Revision : 1.0  initial release
// ============================================================================
module nibble_splitter #(
    parameter int HIGH_FIRST = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] dataIN,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] dataOUT,
    output logic       sel,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       last,
    output logic       byte_done
);

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_FIRST  = 2'd1,
        ST_SECOND = 2'd2
    } state_t;

    localparam logic c_FIRST_SEL = (HIGH_FIRST != 0);

    state_t     r_state;
    logic [7:0] r_hold;
    logic       r_byte_done;

    logic       w_in_xfer;
    logic [3:0] w_first_nib;
    logic [3:0] w_second_nib;

    assign w_in_xfer    = in_valid && in_ready;
    assign w_first_nib  = c_FIRST_SEL ? r_hold[7:4] : r_hold[3:0];
    assign w_second_nib = c_FIRST_SEL ? r_hold[3:0] : r_hold[7:4];
    assign byte_done    = r_byte_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_hold      <= 8'h00;
            r_byte_done <= 1'b0;
        end else begin
            r_byte_done <= (r_state == ST_SECOND) && out_ready;
            if (w_in_xfer) begin
                r_hold <= dataIN;
            end
            case (r_state)
                ST_EMPTY:  if (w_in_xfer) r_state <= ST_FIRST;
                ST_FIRST:  if (out_ready) r_state <= ST_SECOND;
                // A new byte may land in the same cycle the last nibble leaves.
                ST_SECOND: if (out_ready) r_state <= w_in_xfer ? ST_FIRST : ST_EMPTY;
                default:   r_state <= ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        dataOUT   = 4'h0;
        sel       = 1'b0;
        last      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                in_ready = 1'b1;
            end
            ST_FIRST: begin
                out_valid = 1'b1;
                dataOUT   = w_first_nib;
                sel       = c_FIRST_SEL;
            end
            ST_SECOND: begin
                in_ready  = out_ready;
                out_valid = 1'b1;
                dataOUT   = w_second_nib;
                sel       = ~c_FIRST_SEL;
                last      = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_nibble_splitter.sv
`default_nettype none
// Bench for nibble_splitter: both nibble orders side by side, checked every
// cycle against a remaining-nibble-count model plus directed literal vectors.
module tb_nibble_splitter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] dataIN;
    logic       in_valid;
    logic       out_ready;

    logic       in_ready_hi, out_valid_hi, sel_hi, last_hi, byte_done_hi;
    logic [3:0] dataOUT_hi;
    logic       in_ready_lo, out_valid_lo, sel_lo, last_lo, byte_done_lo;
    logic [3:0] dataOUT_lo;

    always #5 clk = ~clk;

    nibble_splitter #(.HIGH_FIRST(1)) dut_hi (
        .clk(clk), .rst(rst), .dataIN(dataIN), .in_valid(in_valid),
        .in_ready(in_ready_hi), .dataOUT(dataOUT_hi), .sel(sel_hi),
        .out_valid(out_valid_hi), .out_ready(out_ready), .last(last_hi),
        .byte_done(byte_done_hi)
    );

    nibble_splitter #(.HIGH_FIRST(0)) dut_lo (
        .clk(clk), .rst(rst), .dataIN(dataIN), .in_valid(in_valid),
        .in_ready(in_ready_lo), .dataOUT(dataOUT_lo), .sel(sel_lo),
        .out_valid(out_valid_lo), .out_ready(out_ready), .last(last_lo),
        .byte_done(byte_done_lo)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: the byte being split and how many of its nibbles are still owed.
    int         m_cnt       = 0;
    logic [7:0] m_byte      = 8'h00;
    logic       m_done      = 1'b0;
    logic       m_live      = 1'b0;
    int         m_accepted  = 0;
    int         m_completed = 0;
    logic       m_in_rdy;

    always @(posedge clk) begin
        if (rst) begin
            m_cnt  = 0;
            m_byte = 8'h00;
            m_done = 1'b0;
            m_live = 1'b1;
        end else if (m_live) begin
            m_in_rdy = (m_cnt == 0) || (m_cnt == 1 && out_ready);
            m_done   = (m_cnt == 1) && out_ready;
            if (m_done) m_completed++;
            if (out_ready && m_cnt != 0) m_cnt--;
            if (in_valid && m_in_rdy) begin
                m_byte = dataIN;
                m_cnt  = 2;
                m_accepted++;
            end
        end
    end

    task automatic chk_variant(input string tag, input bit hf,
                               input logic ir, input logic ov, input logic [3:0] d,
                               input logic s, input logic l, input logic bd);
        logic [3:0] e_d;
        logic       e_s, e_l;
        logic [3:0] hi_n, lo_n;
        hi_n = m_byte[7:4];
        lo_n = m_byte[3:0];
        e_d = 4'h0; e_s = 1'b0; e_l = 1'b0;
        if (m_cnt == 2) begin
            e_d = hf ? hi_n : lo_n; e_s = hf;
        end else if (m_cnt == 1) begin
            e_d = hf ? lo_n : hi_n; e_s = !hf; e_l = 1'b1;
        end
        chk({tag, "_in_ready"}, 32'(ir), 32'((m_cnt == 0) || (m_cnt == 1 && out_ready)));
        chk({tag, "_out_valid"}, 32'(ov), 32'(m_cnt != 0));
        chk({tag, "_dataOUT"}, 32'(d), 32'(e_d));
        chk({tag, "_sel"}, 32'(s), 32'(e_s));
        chk({tag, "_last"}, 32'(l), 32'(e_l));
        chk({tag, "_byte_done"}, 32'(bd), 32'(m_done));
    endtask

    int done_cnt_hi = 0;
    int done_cnt_lo = 0;

    always @(negedge clk) begin
        if (m_live) begin
            chk_variant("hi", 1'b1, in_ready_hi, out_valid_hi, dataOUT_hi, sel_hi, last_hi, byte_done_hi);
            chk_variant("lo", 1'b0, in_ready_lo, out_valid_lo, dataOUT_lo, sel_lo, last_lo, byte_done_lo);
            if (byte_done_hi === 1'b1) done_cnt_hi++;
            if (byte_done_lo === 1'b1) done_cnt_lo++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] seq_bytes [3];
    logic [3:0] seq_nibs  [6];

    initial begin
        int k, cyc, acc0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dataIN = 8'h00;
        repeat (3) tick;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready_hi), 32'd1);
        chk("rst_out_valid", 32'(out_valid_hi), 32'd0);
        chk("rst_dataOUT", 32'(dataOUT_hi), 32'd0);
        chk("rst_sel_last", 32'({sel_hi, last_hi, byte_done_hi}), 32'd0);
        tick;
        rst = 1'b0;
        tick;

        // 0xA5 through both orders, downstream always ready
        dataIN = 8'hA5; in_valid = 1'b1; out_ready = 1'b1;
        tick; in_valid = 1'b0;
        @(negedge clk);
        chk("a5_hi_n1", 32'({dataOUT_hi, sel_hi, last_hi}), 32'({4'hA, 1'b1, 1'b0}));
        chk("a5_lo_n1", 32'({dataOUT_lo, sel_lo, last_lo}), 32'({4'h5, 1'b0, 1'b0}));
        tick;
        @(negedge clk);
        chk("a5_hi_n2", 32'({dataOUT_hi, sel_hi, last_hi}), 32'({4'h5, 1'b0, 1'b1}));
        chk("a5_lo_n2", 32'({dataOUT_lo, sel_lo, last_lo}), 32'({4'hA, 1'b1, 1'b1}));
        tick;
        @(negedge clk);
        chk("a5_done", 32'({byte_done_hi, out_valid_hi}), 32'({1'b1, 1'b0}));

        dataIN = 8'h3C; in_valid = 1'b1;
        tick; in_valid = 1'b0;
        @(negedge clk);
        chk("3c_lo_n1", 32'({dataOUT_lo, sel_lo, last_lo}), 32'({4'hC, 1'b0, 1'b0}));
        tick;
        @(negedge clk);
        chk("3c_lo_n2", 32'({dataOUT_lo, sel_lo, last_lo}), 32'({4'h3, 1'b1, 1'b1}));
        tick; tick;

        // back-to-back bytes, zero bubble
        seq_bytes[0] = 8'h12; seq_bytes[1] = 8'h34; seq_bytes[2] = 8'h56;
        seq_nibs[0] = 4'h1; seq_nibs[1] = 4'h2; seq_nibs[2] = 4'h3;
        seq_nibs[3] = 4'h4; seq_nibs[4] = 4'h5; seq_nibs[5] = 4'h6;
        k = 0; dataIN = seq_bytes[0]; in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (i % 2 == 0) begin
                k++;
                if (k < 3) dataIN = seq_bytes[k];
                else in_valid = 1'b0;
            end
            @(negedge clk);
            chk("b2b_nib", 32'(dataOUT_hi), 32'(seq_nibs[i]));
            chk("b2b_in_ready", 32'(in_ready_hi), 32'(i % 2));
            chk("b2b_valid", 32'(out_valid_hi), 32'd1);
        end
        tick; tick;

        // stall in FIRST with dataIN wiggling
        dataIN = 8'hF0; in_valid = 1'b1; out_ready = 1'b0;
        tick;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_nib", 32'({dataOUT_hi, sel_hi, in_ready_hi}), 32'({4'hF, 1'b1, 1'b0}));
            tick;
            dataIN = 8'(i * 37 + 5);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick;
        @(negedge clk);
        chk("stall_release", 32'({dataOUT_hi, sel_hi, last_hi}), 32'({4'h0, 1'b0, 1'b1}));
        tick; tick;

        // reset while in SECOND aborts the byte
        dataIN = 8'h9E; in_valid = 1'b1; out_ready = 1'b1;
        tick; in_valid = 1'b0;
        tick; rst = 1'b1;
        tick; rst = 1'b0;
        @(negedge clk);
        chk("abort_state", 32'({out_valid_hi, in_ready_hi, dataOUT_hi, byte_done_hi}),
            32'({1'b0, 1'b1, 4'h0, 1'b0}));
        tick;
        @(negedge clk);
        chk("abort_no_done", 32'(byte_done_hi), 32'd0);

        // random traffic, 1000 bytes
        acc0 = m_accepted; cyc = 0;
        while ((m_accepted - acc0) < 1000 && cyc < 20000) begin
            in_valid  = 1'($urandom_range(0, 1));
            dataIN    = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick;
            cyc++;
        end
        chk("random_budget", 32'(m_accepted - acc0 >= 1000), 32'd1);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) tick;
        @(negedge clk);
        chk("done_count_hi", 32'(done_cnt_hi), 32'(m_completed));
        chk("done_count_lo", 32'(done_cnt_lo), 32'(m_completed));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nibble_splitter.md
NIBBLE_SPLITTER -- requirements
Module: nibble_splitter

Interface
REQ-001 Parameter HIGH_FIRST, default 1: 1 = emit upper nibble first; 0 = emit lower nibble first.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 dataIN  input  8  byte offered for splitting.
REQ-005 in_valid  input  1  dataIN holds a valid byte.
REQ-006 in_ready  output  1  block accepts a byte this cycle.
REQ-007 dataOUT  output  4  nibble currently presented.
REQ-008 sel  output  1  1 = dataOUT is bits [7:4] of the held byte; 0 = bits [3:0].
REQ-009 out_valid  output  1  dataOUT/sel are valid.
REQ-010 out_ready  input  1  downstream consumes the nibble this cycle.
REQ-011 last  output  1  presented nibble is the second nibble of its byte.
REQ-012 byte_done  output  1  one-cycle pulse, registered, the cycle after a byte's second nibble is consumed.

Function
REQ-013 States: EMPTY (no byte held), FIRST (first nibble presented), SECOND (second nibble presented).
REQ-014 Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-015 in_ready SHALL be 1 in EMPTY, out_ready in SECOND, 0 in FIRST (combinational from state and out_ready).
REQ-016 out_valid SHALL be 1 in FIRST and SECOND, 0 in EMPTY; no combinational path from in_valid to out_valid.
REQ-017 On input transfer the block SHALL capture dataIN into an 8-bit hold register and enter FIRST next cycle.
REQ-018 In FIRST: dataOUT = hold[7:4], sel = 1 if HIGH_FIRST=1; hold[3:0], sel = 0 otherwise; last = 0.
REQ-019 In SECOND: the opposite half and opposite sel of FIRST; last = 1.
REQ-020 FIRST -> SECOND on output transfer; FIRST holds with dataOUT/sel stable while out_ready = 0.
REQ-021 SECOND -> FIRST on output transfer with simultaneous input transfer (new byte captured, zero bubble).
REQ-022 SECOND -> EMPTY on output transfer without input transfer.
REQ-023 SECOND holds with outputs stable while out_ready = 0; in_ready stays 0 then.
REQ-024 EMPTY -> FIRST on input transfer; otherwise remain EMPTY.
REQ-025 Latency: byte accepted in cycle N presents its first nibble in cycle N+1.
REQ-026 Sustained throughput: one byte per two cycles with in_valid and out_ready held high.
REQ-027 byte_done SHALL be 1 exactly in the cycle after each SECOND output transfer, else 0.
REQ-028 In EMPTY, dataOUT = 0, sel = 0, last = 0.
REQ-029 Hold register SHALL change only on input transfer; dataIN changes without in_ready have no effect.

Reset
REQ-030 rst = 1 at a rising edge SHALL force state EMPTY, hold = 0x00, byte_done = 0, overriding any simultaneous transfer.
REQ-031 After reset: in_ready = 1, out_valid = 0, dataOUT = 0, sel = 0, last = 0.
REQ-032 Reset mid-byte (FIRST or SECOND) SHALL discard remaining nibbles; no byte_done for the aborted byte.

Verification
REQ-033 HIGH_FIRST=1, send 0xA5, out_ready=1 -> cycle+1: dataOUT=0xA, sel=1, last=0; cycle+2: dataOUT=0x5, sel=0, last=1; cycle+3: byte_done=1, out_valid=0.
REQ-034 HIGH_FIRST=0, send 0x3C -> first nibble 0xC with sel=0, then 0x3 with sel=1, last=1.
REQ-035 Bytes 0x12,0x34,0x56 back-to-back, out_ready=1 -> nibbles 1,2,3,4,5,6 on six consecutive cycles, in_ready high every second cycle, no bubbles.
REQ-036 Send 0xF0, hold out_ready=0 for 5 cycles in FIRST -> dataOUT=0xF, sel=1 stable, in_ready=0; then release -> 0x0 follows; dataIN changes during stall ignored.
REQ-037 Send 0x9E, assert rst while in SECOND -> next cycle EMPTY, out_valid=0, hold=0x00, no byte_done pulse.
REQ-038 Random in_valid/out_ready traffic, 1000 bytes -> output nibble stream equals reference byte-split order; count of byte_done pulses equals bytes accepted.
